// File: rtl/pcie_arb_pkg.sv
// Shared definitions for the PCIe virtual-channel arbiter.
//   DATA_WIDTH         : width of every FIFO word
//   NUM_VC             : number of input/output FIFOs (fixed at 4)
//   DEST_MSB/DEST_LSB  : destination field inside a head word
//   state_e            : FSM state encoding, visible on the estado port
package pcie_arb_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int NUM_VC     = 4;
  localparam int DEST_MSB   = 11;
  localparam int DEST_LSB   = 10;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

endpackage

// File: rtl/rr_prioridad4.sv
// Combinational 4-way rotating priority encoder.
//   request[3:0]    : one bit per requester (1 = wants service)
//   last_grant[1:0] : index served most recently; it gets the lowest priority
//   valid           : at least one request is pending
//   grant_idx[1:0]  : first requester found at last_grant+1, +2, +3, +4 (mod 4)
module rr_prioridad4 (
  input  logic [3:0] request,
  input  logic [1:0] last_grant,
  output logic       valid,
  output logic [1:0] grant_idx
);

  logic [1:0] idx;

  // Walk from the farthest offset to the nearest so the nearest requester
  // is the last assignment and therefore wins.
  always_comb begin
    valid     = |request;
    grant_idx = 2'd0;
    idx       = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant + k[1:0];
      if (request[idx]) grant_idx = idx;
    end
  end

endmodule

// File: rtl/arbitro_pcie_vc.sv
// Transaction-layer arbiter: moves words from four input virtual-channel
// FIFOs to four output FIFOs. The source is chosen round-robin, the
// destination comes from the head word's [11:10] field, and output
// almost-full flags stall the arbiter (head-of-line, no VC skipping).
// Also owns the FIFO threshold configuration and a sticky overflow error.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   init, umbral_L/H        : threshold load request and values
//   in_empty, in_data       : input FIFO empty flags and head words
//   out_almost_full/full    : output FIFO status flags
//   pop                     : one-hot read strobe (combinational, same cycle)
//   push, data_out          : one-hot write strobe and word (one cycle later)
//   umbral_L_cfg/H_cfg      : latched thresholds for all FIFOs
//   estado, idle/active/error : FSM state and decoded flags
module arbitro_pcie_vc #(
  parameter int DATA_WIDTH   = pcie_arb_pkg::DATA_WIDTH,
  parameter int UMBRAL_WIDTH = 8,
  parameter int NUM_VC       = pcie_arb_pkg::NUM_VC
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init,
  input  logic [UMBRAL_WIDTH-1:0]      umbral_L,
  input  logic [UMBRAL_WIDTH-1:0]      umbral_H,
  input  logic [NUM_VC-1:0]            in_empty,
  input  logic [NUM_VC*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_VC-1:0]            out_almost_full,
  input  logic [NUM_VC-1:0]            out_full,
  output logic [NUM_VC-1:0]            pop,
  output logic [NUM_VC-1:0]            push,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [UMBRAL_WIDTH-1:0]      umbral_L_cfg,
  output logic [UMBRAL_WIDTH-1:0]      umbral_H_cfg,
  output logic [2:0]                   estado,
  output logic                         idle,
  output logic                         active,
  output logic                         error
);

  import pcie_arb_pkg::*;

  state_e                  state_q;
  logic [1:0]              last_grant_q;
  logic [NUM_VC-1:0]       push_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [UMBRAL_WIDTH-1:0] umbral_l_q;
  logic [UMBRAL_WIDTH-1:0] umbral_h_q;

  logic                    cand_vld;
  logic [1:0]              cand_idx;
  logic [DATA_WIDTH-1:0]   head_w [NUM_VC];
  logic [DATA_WIDTH-1:0]   head_sel;
  logic [1:0]              dest;
  logic                    ovf;
  logic                    grant;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_head
    assign head_w[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_prioridad4 u_rr (
    .request    (~in_empty),
    .last_grant (last_grant_q),
    .valid      (cand_vld),
    .grant_idx  (cand_idx)
  );

  assign head_sel = head_w[cand_idx];
  assign dest     = head_sel[DEST_MSB:DEST_LSB];

  // A push registered last cycle landing on a full FIFO is an overflow.
  assign ovf = |(push_q & out_full);

  // Grant only in ACTIVE and only when nothing of higher priority (reset,
  // overflow, reconfiguration) claims this edge. A stalled head blocks the
  // whole arbiter rather than letting another VC overtake it.
  assign grant = (state_q == ST_ACTIVE) && !reset && !ovf && !init &&
                 cand_vld && !out_almost_full[dest];

  assign pop = grant ? (NUM_VC'(1) << cand_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      last_grant_q <= 2'd3;
      push_q       <= '0;
      data_q       <= '0;
      umbral_l_q   <= '0;
      umbral_h_q   <= '0;
    end else begin
      push_q <= '0;
      if (grant) begin
        push_q       <= NUM_VC'(1) << dest;
        data_q       <= head_sel;
        last_grant_q <= cand_idx;
      end

      // Thresholds follow init in any live state, so the value present on
      // the last init=1 edge is what is held afterwards; frozen in ERROR.
      if (init && !ovf && state_q != ST_ERROR) begin
        umbral_l_q <= umbral_L;
        umbral_h_q <= umbral_H;
      end

      case (state_q)
        ST_RESET:  state_q <= ST_INIT;
        ST_INIT: begin
          if (ovf)        state_q <= ST_ERROR;
          else if (!init) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (ovf)                  state_q <= ST_ERROR;
          else if (init)            state_q <= ST_INIT;
          else if (in_empty != '1)  state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (ovf)                             state_q <= ST_ERROR;
          else if (init)                       state_q <= ST_INIT;
          else if (!grant && in_empty == '1)   state_q <= ST_IDLE;
        end
        ST_ERROR:  state_q <= ST_ERROR;
        default:   state_q <= ST_ERROR;
      endcase
    end
  end

  assign push         = push_q;
  assign data_out     = data_q;
  assign umbral_L_cfg = umbral_l_q;
  assign umbral_H_cfg = umbral_h_q;
  assign estado       = state_q;
  assign idle         = (state_q == ST_IDLE);
  assign active       = (state_q == ST_ACTIVE);
  assign error        = (state_q == ST_ERROR);

endmodule

// File: tb/tb_arbitro_pcie_vc.sv
module tb_arbitro_pcie_vc;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [7:0]  umbral_L, umbral_H;
  logic [3:0]  in_empty;
  logic [47:0] in_data;
  logic [3:0]  out_almost_full, out_full;
  logic [3:0]  pop, push;
  logic [11:0] data_out;
  logic [7:0]  umbral_L_cfg, umbral_H_cfg;
  logic [2:0]  estado;
  logic        idle, active, error;

  int compared   = 0;
  int mismatched = 0;

  // Expected output transfers: {push one-hot, data_out word}
  logic [15:0] exp_q [$];

  arbitro_pcie_vc dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_L(umbral_L), .umbral_H(umbral_H),
    .in_empty(in_empty), .in_data(in_data),
    .out_almost_full(out_almost_full), .out_full(out_full),
    .pop(pop), .push(push), .data_out(data_out),
    .umbral_L_cfg(umbral_L_cfg), .umbral_H_cfg(umbral_H_cfg),
    .estado(estado), .idle(idle), .active(active), .error(error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_heads(input logic [11:0] h0, input logic [11:0] h1,
                           input logic [11:0] h2, input logic [11:0] h3);
    in_data = {h3, h2, h1, h0};
  endtask

  task automatic reset_and_config(input logic [7:0] l, input logic [7:0] h);
    reset = 1'b1; init = 1'b0;
    in_empty = 4'hF; out_full = 4'h0; out_almost_full = 4'h0;
    step(); step();
    reset = 1'b0; init = 1'b1; umbral_L = l; umbral_H = h;
    step();
    init = 1'b0;
    step();
    chk("cfg_idle_estado", 32'(estado), 32'd2);
  endtask

  // Monitor: every cycle the DUT presents a push, pop the scoreboard and compare.
  always @(negedge clk) begin
    if (push !== 4'h0) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_push: got push=%b data=%h expected no push", push, data_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({push, data_out} !== e) begin
          mismatched++;
          $display("FAIL transfer: got push=%b data=%h expected push=%b data=%h",
                   push, data_out, e[15:12], e[11:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] fair_heads [4];
    fair_heads[0] = 12'h011; fair_heads[1] = 12'h122;
    fair_heads[2] = 12'h233; fair_heads[3] = 12'h344;

    reset = 1'b1; init = 1'b0; umbral_L = 8'd0; umbral_H = 8'd0;
    in_empty = 4'hF; in_data = '0; out_almost_full = 4'h0; out_full = 4'h0;

    // Reset / configuration
    step(); step();
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_cfg_L", 32'(umbral_L_cfg), 32'd0);
    chk("rst_cfg_H", 32'(umbral_H_cfg), 32'd0);
    chk("rst_flags", 32'({idle, active, error}), 32'd0);
    reset = 1'b0; init = 1'b1; umbral_L = 8'd2; umbral_H = 8'd6;
    step();
    chk("init_estado", 32'(estado), 32'd1);
    init = 1'b0;
    step();
    chk("idle_estado", 32'(estado), 32'd2);
    chk("cfg_L", 32'(umbral_L_cfg), 32'd2);
    chk("cfg_H", 32'(umbral_H_cfg), 32'd6);
    chk("idle_flag", 32'({idle, active, error}), 32'b100);

    // Single transfer: VC0 head 12'h805 -> destination 2
    in_empty = 4'b1110; set_heads(12'h805, 12'h000, 12'h000, 12'h000);
    #1 chk("single_pop_idle", 32'(pop), 32'd0);
    step();
    chk("single_active", 32'(estado), 32'd3);
    chk("single_active_flag", 32'({idle, active, error}), 32'b010);
    chk("single_pop", 32'(pop), 32'b0001);
    exp_q.push_back({4'b0100, 12'h805});
    step();
    in_empty = 4'hF;
    #1 chk("single_pop_empty", 32'(pop), 32'd0);
    step();
    chk("single_back_idle", 32'(estado), 32'd2);
    chk("single_push_done", 32'(push), 32'd0);

    // Fairness: all VCs non-empty, destination 0 everywhere
    reset_and_config(8'd2, 8'd6);
    in_empty = 4'b0000;
    set_heads(fair_heads[0], fair_heads[1], fair_heads[2], fair_heads[3]);
    step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fair_pop_%0d", i), 32'(pop), 32'(4'b0001 << (i % 4)));
      exp_q.push_back({4'b0001, fair_heads[i % 4]});
      step();
      if (i > 0) chk($sformatf("fair_push_%0d", i), 32'(push), 32'b0001);
    end
    in_empty = 4'hF;
    step(); step();
    chk("fair_back_idle", 32'(estado), 32'd2);

    // Backpressure: VC1 head 12'h4AB -> destination 1, almost full for 3 cycles
    in_empty = 4'b1101; set_heads(12'h000, 12'h4AB, 12'h000, 12'h000);
    out_almost_full = 4'b0010;
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_stall_pop_%0d", i), 32'(pop), 32'd0);
      step();
      chk($sformatf("bp_stall_estado_%0d", i), 32'(estado), 32'd3);
    end
    out_almost_full = 4'b0000;
    #1 chk("bp_release_pop", 32'(pop), 32'b0010);
    exp_q.push_back({4'b0010, 12'h4AB});
    step();
    in_empty = 4'hF;
    step(); step();
    chk("bp_back_idle", 32'(estado), 32'd2);

    // Overflow: push to destination 2 lands on a full FIFO
    in_empty = 4'b1110; set_heads(12'h8CD, 12'h000, 12'h000, 12'h000);
    step();
    chk("ovf_pop", 32'(pop), 32'b0001);
    exp_q.push_back({4'b0100, 12'h8CD});
    step();
    out_full = 4'b0100;
    #1 chk("ovf_pop_blocked", 32'(pop), 32'd0);
    step();
    chk("ovf_estado", 32'(estado), 32'd4);
    chk("ovf_error_flag", 32'({idle, active, error}), 32'b001);
    chk("ovf_push", 32'(push), 32'd0);
    chk("ovf_pop_err", 32'(pop), 32'd0);
    out_full = 4'b0000; in_empty = 4'b0000;
    step();
    chk("ovf_sticky_estado", 32'(estado), 32'd4);
    chk("ovf_sticky_pop", 32'(pop), 32'd0);
    chk("ovf_sticky_push", 32'(push), 32'd0);
    chk("ovf_cfg_held", 32'(umbral_H_cfg), 32'd6);

    // Reconfigure mid-stream
    reset_and_config(8'd2, 8'd6);
    in_empty = 4'b0000;
    set_heads(fair_heads[0], fair_heads[1], fair_heads[2], fair_heads[3]);
    step();
    chk("recfg_pop_a", 32'(pop), 32'b0001);
    exp_q.push_back({4'b0001, fair_heads[0]});
    step();
    init = 1'b1; umbral_L = 8'd1; umbral_H = 8'd7;
    #1 chk("recfg_pop_init", 32'(pop), 32'd0);
    chk("recfg_trailing_push", 32'(push), 32'b0001);
    step();
    chk("recfg_estado", 32'(estado), 32'd1);
    chk("recfg_cfg_L", 32'(umbral_L_cfg), 32'd1);
    chk("recfg_cfg_H", 32'(umbral_H_cfg), 32'd7);
    chk("recfg_push_off", 32'(push), 32'd0);
    chk("recfg_pop_off", 32'(pop), 32'd0);
    init = 1'b0;
    step();
    chk("recfg_idle", 32'(estado), 32'd2);
    step();
    chk("recfg_resume_pop", 32'(pop), 32'b0010);
    exp_q.push_back({4'b0001, fair_heads[1]});
    step();
    in_empty = 4'hF;
    step(); step();
    chk("recfg_back_idle", 32'(estado), 32'd2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
